c2_skid_stage: RTL and testbench

Two-entry registered skid buffer that sits directly downstream of the 4:1 C-module mux stage. It captures the mux's `size`-bit output under a valid/ready handshake and forwards it to the next logic stage in arrival order. The output is registered, so the mux output is isolated from the downstream timing path. A wrapping transfer counter supports throughput checks during verification.

---
 rtl/c2_skid_stage.sv | 48 ++++
 tb/tb_c2_skid_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/c2_skid_stage.sv
// c2_skid_stage: two-entry registered skid buffer with wrapping accepted-word counter.
module c2_skid_stage #(
  parameter int size = 5,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [size-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [size-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      occ,
  output logic [CW-1:0]   xfer_cnt
);
  logic [size-1:0] head, tail, head_n, tail_n;
  logic [1:0] occ_n;
  logic push, pop;
  assign in_ready  = occ != 2'd2;
  assign out_valid = occ != 2'd0;
  assign out_data  = head;
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  // head refills from tail when draining a full buffer, or from the input when it becomes/stays the only word
  always_comb begin
    occ_n  = occ + {1'b0, push} - {1'b0, pop};
    head_n = (pop && occ == 2'd2) ? tail : (push && (occ == 2'd0 || pop)) ? in_data : head;
    tail_n = (push && occ == 2'd1 && !pop) ? in_data : tail;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
      xfer_cnt <= '0;
    end else if (flush) begin
      occ      <= '0;
      xfer_cnt <= '0;
    end else begin
      occ      <= occ_n;
      head     <= head_n;
      tail     <= tail_n;
      xfer_cnt <= xfer_cnt + CW'(push);
    end
  end
endmodule

// File: tb/tb_c2_skid_stage.sv
// tb_c2_skid_stage: directed self-checking bench for the skid stage (CW=8 and CW=3 instances).
module tb_c2_skid_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0] in_data = '0;
  logic in_ready, out_valid, in_ready3, out_valid3;
  logic [4:0] out_data, out_data3;
  logic [1:0] occ, occ3;
  logic [7:0] xfer_cnt;
  logic [2:0] xfer_cnt3;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  c2_skid_stage #(.size(5), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occ(occ), .xfer_cnt(xfer_cnt));

  c2_skid_stage #(.size(5), .CW(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
    .occ(occ3), .xfer_cnt(xfer_cnt3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_occ"}, 32'(occ), 0);
    check({tag, "_ovalid"}, 32'(out_valid), 0);
    check({tag, "_iready"}, 32'(in_ready), 1);
    check({tag, "_xfer"}, 32'(xfer_cnt), 0);
    check({tag, "_odata"}, 32'(out_data), 0);
  endtask

  initial begin
    #1;
    check_reset("rst0");
    step;
    step;
    rst_n = 1'b1;
    step;
    check_reset("idle");

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = 5'(i);
      step;
      check($sformatf("strm_v%0d", i), 32'(out_valid), 1);
      check($sformatf("strm_d%0d", i), 32'(out_data), i);
      check($sformatf("strm_o%0d", i), 32'(occ), 1);
    end
    in_valid = 1'b0;
    step;
    check("strm_empty", 32'(occ), 0);
    check("strm_xfer", 32'(xfer_cnt), 8);

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 5'h0A;
    step;
    check("bp_occ1", 32'(occ), 1);
    in_data = 5'h0B;
    step;
    check("bp_occ2", 32'(occ), 2);
    check("bp_iready", 32'(in_ready), 0);
    check("bp_head", 32'(out_data), 5'h0A);
    in_data = 5'h0C;
    step;
    check("bp_held_occ", 32'(occ), 2);
    check("bp_stable", 32'(out_data), 5'h0A);
    check("bp_xfer", 32'(xfer_cnt), 10);
    out_ready = 1'b1;
    step;
    check("bp_pop0B", 32'(out_data), 5'h0B);
    check("bp_pop_occ", 32'(occ), 1);
    step;
    check("bp_pop0C", 32'(out_data), 5'h0C);
    check("bp_pop0C_occ", 32'(occ), 1);
    in_valid = 1'b0;
    step;
    check("bp_drained", 32'(occ), 0);
    check("bp_xfer2", 32'(xfer_cnt), 11);

    // simultaneous push and pop at occ 1
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 5'h11;
    step;
    check("pp_head11", 32'(out_data), 5'h11);
    out_ready = 1'b1;
    in_data = 5'h12;
    step;
    check("pp_head12", 32'(out_data), 5'h12);
    check("pp_occ", 32'(occ), 1);
    check("pp_xfer", 32'(xfer_cnt), 13);

    // flush priority over push and pop with a full buffer
    out_ready = 1'b0;
    in_data = 5'h13;
    step;
    check("fl_occ2", 32'(occ), 2);
    flush = 1'b1;
    in_data = 5'h1F;
    out_ready = 1'b1;
    step;
    check("fl_occ", 32'(occ), 0);
    check("fl_ovalid", 32'(out_valid), 0);
    check("fl_xfer", 32'(xfer_cnt), 0);
    check("fl_xfer3", 32'(xfer_cnt3), 0);
    flush = 1'b0;
    in_valid = 1'b0;
    step;
    check("fl_no1F", 32'(out_valid), 0);
    check("fl_xfer_hold", 32'(xfer_cnt), 0);

    // counter wrap on the CW=3 instance
    in_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_data = 5'(i);
      step;
      check($sformatf("wrap_%0d", i), 32'(xfer_cnt3), i % 8);
    end
    check("wrap_cw8", 32'(xfer_cnt), 9);
    in_valid = 1'b0;
    step;

    // asynchronous reset with a full buffer
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 5'h05;
    step;
    in_data = 5'h06;
    step;
    check("ar_full", 32'(occ), 2);
    check("ar_head", 32'(out_data), 5'h05);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    step;
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 5'h07;
    step;
    check("ar_first_push", 32'(out_data), 5'h07);
    check("ar_first_xfer", 32'(xfer_cnt), 1);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
